// File: rtl/multi_step_gen.sv
// Multi-channel step/direction pulse generator with direction setup,
// one-deep request buffering and a signed position counter per channel.
module multi_step_gen #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16,
  parameter int POS_W    = 32,
  parameter bit STEP_POL = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CNT_W-1:0]          pre_n,
  input  logic [CNT_W-1:0]          pulse_n,
  input  logic [CNT_W-1:0]          post_n,
  input  logic [CNT_W-1:0]          dir_setup_n,
  input  logic [CHANNELS-1:0]       step_stb,
  input  logic [CHANNELS-1:0]       step_dir,
  input  logic [CHANNELS-1:0]       pos_load,
  input  logic [POS_W-1:0]          pos_load_val,
  output logic [CHANNELS-1:0]       step,
  output logic [CHANNELS-1:0]       dir,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       missed,
  output logic [CHANNELS*POS_W-1:0] pos
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRSET = 2'd1,
    RUN    = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
  localparam logic [POS_W-1:0] P_ONE = POS_W'(1);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_e           st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] pulse_q, pulse_d;
    logic [CNT_W-1:0] post_q, post_d;
    logic [CNT_W-1:0] setup_q, setup_d;
    logic             pend_q, pend_d;
    logic             pdir_q, pdir_d;
    logic             dir_q, dir_d;
    logic             act_q, act_d;
    logic             miss_q, miss_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             done;
    logic             start;
    logic             sdir;

    always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q;
      pre_d   = pre_q;
      pulse_d = pulse_q;
      post_d  = post_q;
      setup_d = setup_q;
      pend_d  = pend_q;
      pdir_d  = pdir_q;
      dir_d   = dir_q;
      miss_d  = 1'b0;
      pos_d   = pos_q;
      start   = 1'b0;
      sdir    = step_dir[g];
      done    = (st_q == RUN) && (cnt_q >= post_q);
      act_d   = (st_q == RUN) && (cnt_q >= pre_q)
                && (cnt_q < pulse_q);

      unique case (st_q)
        IDLE:   start = step_stb[g];
        DIRSET: begin
          cnt_d = cnt_q + C_ONE;
          if (cnt_q >= setup_q) begin
            st_d  = RUN;
            cnt_d = C_ONE;
          end
        end
        RUN:    cnt_d = cnt_q + C_ONE;
        default: begin
          st_d  = IDLE;
          cnt_d = '0;
        end
      endcase

      // The buffered request goes first; a same-edge strobe refills it.
      if (done) begin
        if (pend_q) begin
          start  = 1'b1;
          sdir   = pdir_q;
          pend_d = step_stb[g];
          pdir_d = step_dir[g];
        end else if (step_stb[g]) begin
          start = 1'b1;
        end else begin
          st_d  = IDLE;
          cnt_d = '0;
        end
      end else if (st_q != IDLE && step_stb[g]) begin
        if (!pend_q) begin
          pend_d = 1'b1;
          pdir_d = step_dir[g];
        end else begin
          miss_d = 1'b1;
        end
      end

      if (start) begin
        pre_d   = pre_n;
        pulse_d = pulse_n;
        post_d  = post_n;
        setup_d = dir_setup_n;
        dir_d   = sdir;
        cnt_d   = C_ONE;
        if (sdir != dir_q && dir_setup_n != '0) st_d = DIRSET;
        else                                    st_d = RUN;
      end

      // A rising step counts in the direction it was issued with.
      if (pos_load[g])          pos_d = pos_load_val;
      else if (act_d && !act_q) pos_d = dir_q ? pos_q + P_ONE
                                              : pos_q - P_ONE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        st_q    <= IDLE;
        cnt_q   <= '0;
        pre_q   <= '0;
        pulse_q <= '0;
        post_q  <= '0;
        setup_q <= '0;
        pend_q  <= 1'b0;
        pdir_q  <= 1'b0;
        dir_q   <= 1'b0;
        act_q   <= 1'b0;
        miss_q  <= 1'b0;
        pos_q   <= '0;
      end else begin
        st_q    <= st_d;
        cnt_q   <= cnt_d;
        pre_q   <= pre_d;
        pulse_q <= pulse_d;
        post_q  <= post_d;
        setup_q <= setup_d;
        pend_q  <= pend_d;
        pdir_q  <= pdir_d;
        dir_q   <= dir_d;
        act_q   <= act_d;
        miss_q  <= miss_d;
        pos_q   <= pos_d;
      end
    end

    assign step[g]   = STEP_POL ? act_q : ~act_q;
    assign dir[g]    = dir_q;
    assign busy[g]   = (st_q != IDLE);
    assign missed[g] = miss_q;
    assign pos[g*POS_W +: POS_W] = pos_q;
  end

endmodule

// File: doc/multi_step_gen.md
# multi_step_gen

Multi-channel step/direction pulse generator for stepper drivers: the parametrised successor of the single-channel step generator. Each channel accepts step requests, applies a direction-setup delay on reversal, shapes a step pulse, and buffers one request while busy instead of dropping it. Each channel also tracks a signed position counter. The block sits between the motion planner's step strobes and the driver pins.

## Interface

- CHANNELS, 4: number of independent motor channels
- CNT_W, 16: width of timing counters and timing inputs
- POS_W, 32: width of each signed position counter
- STEP_POL, 1: active level of `step` (1 = active-high)

- clk  in  1  sole clock; all logic is rising-edge
- reset_n  in  1  asynchronous, active-low reset
- pre_n  in  CNT_W  step-active threshold (counts)
- pulse_n  in  CNT_W  step-inactive threshold
- post_n  in  CNT_W  step-complete threshold
- dir_setup_n  in  CNT_W  cycles inserted after a direction change
- step_stb  in  CHANNELS  per-channel step request, sampled each edge
- step_dir  in  CHANNELS  direction for the request (1 = positive)
- pos_load  in  CHANNELS  load position counter
- pos_load_val  in  POS_W  value for pos_load, shared by all channels
- step  out  CHANNELS  step pulse, polarity per STEP_POL
- dir  out  CHANNELS  direction output
- busy  out  CHANNELS  channel is not IDLE
- missed  out  CHANNELS  one-cycle flag: request dropped
- pos  out  CHANNELS*POS_W  signed position; channel i is at [i*POS_W +: POS_W]

## Operation

- Each channel is independent, with states IDLE, DIRSET and RUN, a CNT_W counter `cnt`, and a one-entry pending buffer (valid bit + dir).
- Acceptance (edge E0): `step_stb` high while IDLE, or at the completion edge of the current step.
  - On acceptance, the block latches pre_n, pulse_n, post_n and dir_setup_n. Input changes mid-step have no effect.
- If the accepted dir differs from the current `dir` output and dir_setup_n>0:
  - `dir` updates at E0 and the channel enters DIRSET for dir_setup_n cycles.
  - It then enters RUN with cnt=1. All later timing shifts by dir_setup_n.
- Otherwise, `dir` updates at E0 (no-op if equal) and the channel enters RUN with cnt=1.
- RUN: cnt increments by 1 per cycle. The step register at each edge evaluates to active iff pre_n <= cnt < pulse_n, using the current cnt.
- Completion: the edge at which cnt == post_n (or cnt >= post_n) is sampled. At that edge, in priority order:
  - pending valid → start the pending request; pending takes the new strobe if present.
  - else `step_stb` → start it directly.
  - else → IDLE, cnt=0.
- Request while DIRSET/RUN, not at the completion edge:
  - pending empty → store it.
  - pending full → drop it; `missed` high for exactly one cycle after that edge.
- Position: at the edge where `step` goes inactive→active, pos ±1 by latched dir (1 → +1). Wraps two's complement.
- `pos_load` loads pos_load_val at that edge. A load beats a same-edge increment, and the increment is lost.
- Degenerate thresholds:
  - pulse_n <= pre_n → no pulse and no pos change, but the step still completes at post_n.
  - post_n <= 1 → completion at the first RUN edge.

## Timing

- Reset values: step = ~STEP_POL (inactive), dir=0, busy=0, missed=0, pos=0, pending empty, all channels IDLE.
- Reset is asynchronous at any point. An in-flight step and the pending request are discarded. No pulse completes after reset.
- All outputs are registered. There is no combinational input→output path.
- With no direction change and acceptance at E0:
  - step active after edges E_pre_n … E_(pulse_n−1); width pulse_n−pre_n cycles.
  - completion edge is E_post_n.
  - back-to-back period is exactly post_n cycles.
- busy goes high at E0 and stays high until the completion edge with no further work.
- pos changes at the same edge that step becomes active.

## Test plan

- pre=2, pulse=5, post=10, setup=0; ch0 stb+dir=1 at E0 → step active E2–E4, inactive at E5; pos=1 at E2; busy low at E10.
- Same params; second stb at E3 → buffered, no missed; step2 rises at E12; pos=2.
- Same params; stbs at E1, E3 → E1 buffered; E3 dropped, missed high one cycle after E3; stb at E10 (completion, pending full) → no missed.
- dir_setup_n=4; dir 1 then dir 0 back-to-back → dir falls at E10, step2 rises at E16, pos returns to 0; no setup when dir unchanged.
- pos_load with val=0x7FFFFFFF, then one dir=1 step → pos=0x80000000; load on increment edge → pos=load value.
- reset_n low mid-pulse with pending full on ch0–ch3 → all outputs at reset values immediately; no pulse after release until a new stb.
